// File: rtl/avalon_streaming_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package avalon_streaming_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width that stays at least one bit wide for tiny port counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avst_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is used.
module avst_rr_pick
    import avalon_streaming_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     grant,
    output logic                 any_req
);

    int               idx;
    logic [IDX_W-1:0] idx_v;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = 0;
        idx_v   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_v = IDX_W'(idx);
            if (req[idx_v]) begin
                grant = idx_v;
            end
        end
    end

endmodule

// File: rtl/avalon_streaming_arbiter.sv
// Round-robin Avalon-ST arbiter, bounded bursts, channel-tagged output (AVALON_STREAMING_ARBITER_PKT_LOCK_EN: hold grant to EOP).
// Latency: 1 cycle accept-to-output, plus a 1-cycle arbitration bubble per grant.
// Backpressure: asi_ready follows aso_ready combinationally; the held output beat stays stable while stalled.
module avalon_streaming_arbiter
    import avalon_streaming_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_W    = 8,
    parameter  int BURST_LEN = 4,
    localparam int IDX_W     = idx_width(NUM_PORTS),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          asi_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   asi_data,
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
    input  logic [NUM_PORTS-1:0]          asi_eop,
    output logic                          aso_eop,
`endif
    output logic [NUM_PORTS-1:0]          asi_ready,
    output logic                          aso_valid,
    output logic [DATA_W-1:0]             aso_data,
    output logic [IDX_W-1:0]              aso_channel,
    input  logic                          aso_ready
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               aso_valid_q, aso_valid_d;
    logic [DATA_W-1:0]  aso_data_q, aso_data_d;
    logic [IDX_W-1:0]   aso_channel_q, aso_channel_d;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
    logic               aso_eop_q, aso_eop_d;
`endif

    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic               slot_free;
    logic               accept;
    logic               release_grant;

    avst_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req     (asi_valid),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        slot_free     = !aso_valid_q || aso_ready;
        accept        = (state_q == GRANT) && slot_free && asi_valid[grant_q];
        release_grant = 1'b0;

        asi_ready = '0;
        if (state_q == GRANT && slot_free) begin
            asi_ready[grant_q] = 1'b1;
        end

        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        aso_valid_d   = aso_valid_q;
        aso_data_d    = aso_data_q;
        aso_channel_d = aso_channel_q;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        aso_eop_d     = aso_eop_q;
`endif

        // A reload in the same cycle as an output transfer keeps the stream bubble-free.
        if (accept) begin
            aso_valid_d   = 1'b1;
            aso_data_d    = asi_data[int'(grant_q)*DATA_W +: DATA_W];
            aso_channel_d = grant_q;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            aso_eop_d     = asi_eop[grant_q];
`endif
        end else if (aso_ready) begin
            aso_valid_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (accept && beat_cnt_q != CNT_W'(BURST_LEN)) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
                release_grant = accept && asi_eop[grant_q];
`else
                release_grant = (beat_cnt_d == CNT_W'(BURST_LEN)) ||
                                (slot_free && !asi_valid[grant_q]);
`endif
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            aso_valid_q   <= 1'b0;
            aso_data_q    <= '0;
            aso_channel_q <= '0;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            aso_eop_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            aso_valid_q   <= aso_valid_d;
            aso_data_q    <= aso_data_d;
            aso_channel_q <= aso_channel_d;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            aso_eop_q     <= aso_eop_d;
`endif
        end
    end

    assign aso_valid   = aso_valid_q;
    assign aso_data    = aso_data_q;
    assign aso_channel = aso_channel_q;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
    assign aso_eop     = aso_eop_q;
`endif

endmodule

// File: tb/tb_avalon_streaming_arbiter.sv
// Bench for avalon_streaming_arbiter: cycle model from the arbitration rules plus directed literal checks.
module tb_avalon_streaming_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  asi_valid;
    logic [N*DW-1:0] asi_data;
    logic [N-1:0]  asi_ready;
    logic          aso_valid;
    logic [DW-1:0] aso_data;
    logic [1:0]    aso_channel;
    logic          aso_ready;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
    logic [N-1:0]  asi_eop;
    logic          aso_eop;
`endif

    avalon_streaming_arbiter #(
        .NUM_PORTS (N),
        .DATA_W    (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .asi_valid   (asi_valid),
        .asi_data    (asi_data),
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        .asi_eop     (asi_eop),
        .aso_eop     (aso_eop),
`endif
        .asi_ready   (asi_ready),
        .aso_valid   (aso_valid),
        .aso_data    (aso_data),
        .aso_channel (aso_channel),
        .aso_ready   (aso_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [7:0] src_q [N][$];
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
    bit         src_e [N][$];
    bit         rec_e [$];
`endif
    logic [7:0] rec_d [$];
    int         rec_c [$];
    int         rec_cyc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner=-1 means nobody holds the grant.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    bit         m_ovalid = 1'b0;
    logic [7:0] m_odata = 8'h00;
    int         m_ochan = 0;
    bit         m_oeop  = 1'b0;

    always @(posedge clk) begin
        bit free, take, done, found;
        cyc++;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
            m_ovalid = 1'b0; m_odata = 8'h00; m_ochan = 0; m_oeop = 1'b0;
        end else begin
            free = !m_ovalid || aso_ready;
            take = (m_owner >= 0) && free && asi_valid[2'(m_owner)];
            if (take) begin
                m_ovalid = 1'b1;
                m_odata  = asi_data[m_owner*DW +: DW];
                m_ochan  = m_owner;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
                m_oeop   = asi_eop[2'(m_owner)];
`endif
            end else if (aso_ready) begin
                m_ovalid = 1'b0;
            end
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && asi_valid[2'((m_ptr + k) % N)]) begin
                        m_owner = (m_ptr + k) % N;
                        found   = 1'b1;
                    end
                end
                m_cnt = 0;
            end else begin
                if (take) m_cnt++;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
                done = take && asi_eop[2'(m_owner)];
`else
                done = (m_cnt == BL) || (free && !asi_valid[2'(m_owner)]);
`endif
                if (done) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus capture of every output transfer.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            exp_rdy = '0;
            if (m_owner >= 0 && (!m_ovalid || aso_ready)) exp_rdy[2'(m_owner)] = 1'b1;
            chk("asi_ready", 32'(asi_ready), 32'(exp_rdy));
            chk("aso_valid", 32'(aso_valid), 32'(m_ovalid));
            if (m_ovalid) begin
                chk("aso_data", 32'(aso_data), 32'(m_odata));
                chk("aso_channel", 32'(aso_channel), 32'(m_ochan));
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
                chk("aso_eop", 32'(aso_eop), 32'(m_oeop));
`endif
            end
        end
        if (!reset && aso_valid && aso_ready) begin
            rec_d.push_back(aso_data);
            rec_c.push_back(int'(aso_channel));
            rec_cyc.push_back(cyc);
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            rec_e.push_back(aso_eop);
`endif
        end
    end

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            asi_valid[i]          = (src_q[i].size() > 0);
            asi_data[i*DW +: DW]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            asi_eop[i]            = (src_e[i].size() > 0) ? src_e[i][0] : 1'b0;
`endif
        end
    endfunction

    // One clock: note transfers at mid-cycle, advance past the edge, then retire them.
    task automatic tick();
        logic [N-1:0] xfer;
        @(negedge clk);
        xfer = asi_valid & asi_ready & {N{!reset}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                void'(src_q[i].pop_front());
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
                void'(src_e[i].pop_front());
`endif
            end
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int p, input logic [7:0] d);
        src_q[p].push_back(d);
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        src_e[p].push_back(1'b0);
`endif
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
            src_e[i].delete();
`endif
        end
        rec_d.delete(); rec_c.delete(); rec_cyc.delete();
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        rec_e.delete();
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        drive();
        tick();
        reset = 1'b0;
        rec_d.delete(); rec_c.delete(); rec_cyc.delete();
`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        rec_e.delete();
`endif
    endtask

    initial begin
        int         wait_n;
        logic [7:0] held_d;
        logic [1:0] held_c;

        reset     = 1'b1;
        aso_ready = 1'b1;
        clear_all();
        drive();
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("rst_aso_valid", 32'(aso_valid), 32'd0);
        chk("rst_asi_ready", 32'(asi_ready), 32'd0);
        chk("rst_aso_data", 32'(aso_data), 32'd0);
        chk("rst_aso_channel", 32'(aso_channel), 32'd0);

        // Single source on port 2.
        push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
        drive();
        ticks(2);
        #2;
        chk("t2_first_vld", 32'(aso_valid), 32'd1);
        chk("t2_first_dat", 32'(aso_data), 32'h11);
        chk("t2_first_ch", 32'(aso_channel), 32'd2);
        ticks(6);
        chk("t2_count", 32'(rec_d.size()), 32'd3);
        for (int j = 0; j < 3 && j < rec_d.size(); j++) begin
            chk("t2_dat", 32'(rec_d[j]), 32'(8'h11 * (j + 1)));
            chk("t2_ch", 32'(rec_c[j]), 32'd2);
            chk("t2_back_to_back", 32'(rec_cyc[j] - rec_cyc[0]), 32'(j));
        end

        // All four ports streaming: bursts of four, rotating 0,1,2,3.
        do_reset();
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 8; k++) push(p, 8'(p * 16 + k));
        drive();
        ticks(45);
        chk("t3_count", 32'(rec_d.size()), 32'd32);
        for (int j = 0; j < 32 && j < rec_d.size(); j++) begin
            chk("t3_ch", 32'(rec_c[j]), 32'((j / 4) % 4));
            chk("t3_dat", 32'(rec_d[j]), 32'(((j / 4) % 4) * 16 + (j / 16) * 4 + (j % 4)));
        end
        if (rec_cyc.size() >= 5) begin
            chk("t3_in_burst_gap", 32'(rec_cyc[1] - rec_cyc[0]), 32'd1);
            chk("t3_between_burst_gap", 32'(rec_cyc[4] - rec_cyc[3]), 32'd2);
        end

        // Backpressure mid-burst on port 0.
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 8'(8'hA0 + k));
        drive();
        wait_n = 0;
        while (rec_d.size() < 2 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        chk("t4_reach_stall_point", 32'(wait_n < 20), 32'd1);
        aso_ready = 1'b0;
        drive();
        #2;
        held_d = aso_data;
        held_c = aso_channel;
        chk("t4_held_beat", 32'(held_d), 32'hA2);
        for (int s = 0; s < 5; s++) begin
            chk("t4_stall_dat", 32'(aso_data), 32'(held_d));
            chk("t4_stall_ch", 32'(aso_channel), 32'(held_c));
            chk("t4_stall_rdy", 32'(asi_ready), 32'd0);
            tick();
            #2;
        end
        aso_ready = 1'b1;
        drive();
        ticks(15);
        chk("t4_count", 32'(rec_d.size()), 32'd6);
        for (int j = 0; j < 6 && j < rec_d.size(); j++)
            chk("t4_dat", 32'(rec_d[j]), 32'(8'hA0 + j));

        // Starvation release: port 1 runs dry, pending port 3 goes next.
        do_reset();
        push(1, 8'hB0); push(1, 8'hB1);
        push(3, 8'hD0); push(3, 8'hD1); push(3, 8'hD2);
        drive();
        ticks(15);
        chk("t5_count", 32'(rec_d.size()), 32'd5);
        for (int j = 0; j < 5 && j < rec_c.size(); j++)
            chk("t5_ch", 32'(rec_c[j]), (j < 2) ? 32'd1 : 32'd3);

        // Reset while a beat is held on the output.
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 8'(8'hC0 + k));
        drive();
        ticks(3);
        #2;
        chk("t1_pre_reset_vld", 32'(aso_valid), 32'd1);
        reset = 1'b1;
        clear_all();
        push(3, 8'hE3);
        push(1, 8'hE1);
        drive();
        tick();
        reset = 1'b0;
        #2;
        chk("t1_post_reset_vld", 32'(aso_valid), 32'd0);
        chk("t1_post_reset_rdy", 32'(asi_ready), 32'd0);
        rec_d.delete(); rec_c.delete(); rec_cyc.delete();
        ticks(8);
        chk("t1_count", 32'(rec_c.size()), 32'd2);
        if (rec_c.size() > 0) begin
            chk("t1_first_grant", 32'(rec_c[0]), 32'd1);
            chk("t1_first_dat", 32'(rec_d[0]), 32'hE1);
        end

`ifdef AVALON_STREAMING_ARBITER_PKT_LOCK_EN
        // Packet lock: 7-beat packet on port 0 is never split.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            src_q[0].push_back(8'(8'h50 + k));
            src_e[0].push_back(k == 6);
        end
        src_q[1].push_back(8'h60); src_e[1].push_back(1'b0);
        src_q[1].push_back(8'h61); src_e[1].push_back(1'b1);
        drive();
        ticks(25);
        chk("t6_count", 32'(rec_c.size()), 32'd9);
        for (int j = 0; j < 9 && j < rec_c.size(); j++) begin
            chk("t6_ch", 32'(rec_c[j]), (j < 7) ? 32'd0 : 32'd1);
            chk("t6_eop", 32'(rec_e[j]), (j == 6 || j == 8) ? 32'd1 : 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
